agu_seq_ctrl: RTL and testbench
===============================

// Module: agu_seq_ctrl
// PURPOSE
//  Job sequencer for one address generation unit (agu) in the MVU datapath.
//  Accepts a job descriptor (jumps, loop lengths, step count) over a valid/ready handshake.
//  Latches the job config and drives it onto the agu. Pulses agu clear, then issues the
//  requested number of steps, honouring stall, and pulses done once the pipeline drains.
//  Sits between the MVU command front-end and the agu feeding memory read/write ports.
// PARAMETERS
//  BWADDR    21  address / jump width (matches agu)
//  BWLENGTH   8  loop-length width (matches agu)
//  NJUMPS     5  number of jumps; lengths are NJUMPS-1 entries
//  BWCOUNT   24  step-count width
//  PIPE_LAT   2  cycles from last agu_step until its address is consumed downstream
// PORTS
//  clk          in   1                   clock, all logic on posedge
//  rst_n        in   1                   synchronous reset, active-low
//  start_valid  in   1                   job descriptor valid
//  start_ready  out  1                   sequencer can accept a job (high only in IDLE)
//  cfg_j        in   NJUMPS*BWADDR       jumps, j[k] at bits [k*BWADDR +: BWADDR]
//  cfg_l        in   (NJUMPS-1)*BWLENGTH lengths, l[k] (k=1..NJUMPS-1) at [(k-1)*BWLENGTH +: BWLENGTH]
//  cfg_count    in   BWCOUNT             total agu steps for the job
//  stall        in   1                   downstream backpressure; suppresses agu_step
//  abort        in   1                   cancel current job
//  agu_clr      out  1                   to agu clr
//  agu_step     out  1                   to agu step
//  agu_j        out  NJUMPS*BWADDR       latched jumps, to agu j
//  agu_l        out  (NJUMPS-1)*BWLENGTH latched lengths, to agu l
//  busy         out  1                   state != IDLE
//  remaining    out  BWCOUNT             steps not yet issued
//  done         out  1                   one-cycle pulse, job completed
//  aborted      out  1                   one-cycle pulse, job cancelled
// BEHAVIOUR
//  FSM states: IDLE, LOAD, RUN, DRAIN.
//  Reset (rst_n=0 at posedge): state=IDLE; agu_j, agu_l, remaining and drain counter = 0;
//   done and aborted = 0. agu_clr = ~rst_n | (state==LOAD), so agu is held clear during reset.
//  IDLE: start_ready=1. On start_valid: latch cfg_j/cfg_l into agu_j/agu_l and cfg_count into
//   remaining, then go to LOAD. abort is ignored in IDLE.
//  LOAD: exactly 1 cycle with agu_clr=1 and agu_step=0. Next state is RUN if remaining != 0.
//   If remaining == 0, go to IDLE and pulse done; no steps are issued and PIPE_LAT does not apply.
//  RUN: agu_step = ~stall & ~abort (combinational from registered state).
//   Each issued step decrements remaining.
//   Step issued with remaining==1: go to DRAIN and load drain counter with PIPE_LAT.
//  DRAIN: agu_step=0. Drain counter decrements each cycle. At 0: go to IDLE and pulse done.
//  done timing: last step in cycle T gives done=1 in cycle T+1+PIPE_LAT, and state is IDLE
//   in that same cycle. start_ready=1 in that cycle, so back-to-back jobs are accepted.
//  abort in LOAD/RUN/DRAIN: no agu_step in that cycle; next cycle state=IDLE and aborted=1.
//   done is not pulsed. agu_j/agu_l hold their values. remaining holds the unissued count.
//  agu_j/agu_l change only on job acceptance and are stable for the whole job.
//  start_valid while busy: ignored (start_ready=0), no state change.
//  stall and abort in the same RUN cycle: abort wins.
//  Reset mid-job: behaves as reset. Outputs as listed above; no done or aborted pulse.
//  remaining never wraps: it only decrements when a step is issued with remaining >= 1.
// TESTING (PIPE_LAT=2; job accepted at the cycle-0 edge, so LOAD is cycle 1)
//  1 count=5, stall=0 -> agu_clr=1 in cycle 1; agu_step=1 in cycles 2-6; done=1 only in cycle 9;
//    agu_j/agu_l equal the cfg values throughout.
//  2 count=4, stall=1 in cycles 3-4 -> steps in cycles 2,5,6,7; remaining goes 4,3,3,3,2,1,0;
//    done in cycle 10.
//  3 count=0 -> agu_clr in cycle 1; done in cycle 2; agu_step never asserted.
//  4 count=6, abort=1 in cycle 4 (2 steps issued) -> no step in cycle 4; cycle 5: aborted=1,
//    start_ready=1, remaining=4; done never asserted.
//  5 rst_n=0 for one cycle during RUN -> next cycle IDLE, agu_clr=1 during the reset cycle,
//    agu_j=0, remaining=0, no done.
//  6 start_valid held high with a second job -> second job ignored while busy; accepted in the
//    done cycle; its LOAD follows immediately.

Source files
------------

// File: rtl/agu_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : agu_seq_ctrl
// Description : Job sequencer for one address generation unit. A job
//               descriptor (jumps, loop lengths, step count) is accepted
//               over a valid/ready handshake and latched onto the agu.
//               The agu is cleared for one cycle, then the requested number
//               of steps is issued, honouring stall. done pulses once the
//               last address has drained through the downstream pipeline.
//               abort cancels a job at any point after acceptance.
// Ports       : clk, rst_n (sync, active-low)
//               start_valid / start_ready : job handshake (ready only in IDLE)
//               cfg_j, cfg_l, cfg_count   : job descriptor
//               stall, abort              : run-time control
//               agu_clr, agu_step, agu_j, agu_l : agu drive
//               busy, remaining, done, aborted  : status
// Revision    : 1.0 - initial release
// ============================================================================
module agu_seq_ctrl #(
    parameter int BWADDR   = 21,
    parameter int BWLENGTH = 8,
    parameter int NJUMPS   = 5,
    parameter int BWCOUNT  = 24,
    parameter int PIPE_LAT = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_valid,
    output logic                           start_ready,
    input  logic [NJUMPS*BWADDR-1:0]       cfg_j,
    input  logic [(NJUMPS-1)*BWLENGTH-1:0] cfg_l,
    input  logic [BWCOUNT-1:0]             cfg_count,
    input  logic                           stall,
    input  logic                           abort,
    output logic                           agu_clr,
    output logic                           agu_step,
    output logic [NJUMPS*BWADDR-1:0]       agu_j,
    output logic [(NJUMPS-1)*BWLENGTH-1:0] agu_l,
    output logic                           busy,
    output logic [BWCOUNT-1:0]             remaining,
    output logic                           done,
    output logic                           aborted
);

    // Drain counter must hold PIPE_LAT; keep at least one bit when PIPE_LAT is 0.
    localparam int BWDRAIN = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);

    localparam logic [BWDRAIN-1:0] C_DRAIN_LOAD = BWDRAIN'(PIPE_LAT);
    localparam logic [BWDRAIN-1:0] C_DRAIN_ONE  = BWDRAIN'(1);
    localparam logic [BWCOUNT-1:0] C_CNT_ONE    = BWCOUNT'(1);
    localparam logic [BWCOUNT-1:0] C_CNT_ZERO   = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [BWCOUNT-1:0]   remaining_next;
    logic [BWDRAIN-1:0]   drain_cnt;
    logic [BWDRAIN-1:0]   drain_next;
    logic                 done_next;
    logic                 aborted_next;
    logic                 accept;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            remaining <= '0;
            drain_cnt <= '0;
            agu_j     <= '0;
            agu_l     <= '0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            drain_cnt <= drain_next;
            done      <= done_next;
            aborted   <= aborted_next;
            // Job config only moves on acceptance, so it is stable for the job.
            if (accept) begin
                agu_j <= cfg_j;
                agu_l <= cfg_l;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        drain_next     = drain_cnt;
        done_next      = 1'b0;
        aborted_next   = 1'b0;
        accept         = 1'b0;
        agu_step       = 1'b0;

        case (state)
            ST_IDLE: begin
                // abort has no meaning without a job in flight.
                if (start_valid) begin
                    accept         = 1'b1;
                    remaining_next = cfg_count;
                    state_next     = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (abort) begin
                    state_next   = ST_IDLE;
                    aborted_next = 1'b1;
                end else if (remaining == C_CNT_ZERO) begin
                    // Empty job: nothing enters the pipeline, so no drain wait.
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end else begin
                    state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                if (abort) begin
                    state_next   = ST_IDLE;
                    aborted_next = 1'b1;
                end else if (!stall) begin
                    agu_step = 1'b1;
                    if (remaining != C_CNT_ZERO) begin
                        remaining_next = remaining - C_CNT_ONE;
                    end
                    if (remaining <= C_CNT_ONE) begin
                        if (PIPE_LAT == 0) begin
                            state_next = ST_IDLE;
                            done_next  = 1'b1;
                        end else begin
                            state_next = ST_DRAIN;
                            drain_next = C_DRAIN_LOAD;
                        end
                    end
                end
            end

            ST_DRAIN: begin
                if (abort) begin
                    state_next   = ST_IDLE;
                    aborted_next = 1'b1;
                end else if (drain_cnt <= C_DRAIN_ONE) begin
                    // done is registered, so leaving one count early lands the
                    // pulse exactly PIPE_LAT cycles after the post-step cycle.
                    state_next = ST_IDLE;
                    drain_next = '0;
                    done_next  = 1'b1;
                end else begin
                    drain_next = drain_cnt - C_DRAIN_ONE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign start_ready = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    // Hold the agu clear while in reset as well as during LOAD.
    assign agu_clr     = ~rst_n | (state == ST_LOAD);

endmodule
`default_nettype wire

// File: tb/tb_agu_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_agu_seq_ctrl
// Description : Directed self-checking bench for agu_seq_ctrl. Each job is
//               driven cycle by cycle from the acceptance edge (cycle 0) with
//               hand-computed step, clear, done and aborted timelines.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_agu_seq_ctrl;

    localparam int BWADDR   = 21;
    localparam int BWLENGTH = 8;
    localparam int NJUMPS   = 5;
    localparam int BWCOUNT  = 24;
    localparam int PIPE_LAT = 2;

    logic                           clk;
    logic                           rst_n;
    logic                           start_valid;
    logic                           start_ready;
    logic [NJUMPS*BWADDR-1:0]       cfg_j;
    logic [(NJUMPS-1)*BWLENGTH-1:0] cfg_l;
    logic [BWCOUNT-1:0]             cfg_count;
    logic                           stall;
    logic                           abort;
    logic                           agu_clr;
    logic                           agu_step;
    logic [NJUMPS*BWADDR-1:0]       agu_j;
    logic [(NJUMPS-1)*BWLENGTH-1:0] agu_l;
    logic                           busy;
    logic [BWCOUNT-1:0]             remaining;
    logic                           done;
    logic                           aborted;

    int n_vec = 0;
    int n_err = 0;
    int rem_exp [0:15];

    agu_seq_ctrl #(
        .BWADDR   (BWADDR),
        .BWLENGTH (BWLENGTH),
        .NJUMPS   (NJUMPS),
        .BWCOUNT  (BWCOUNT),
        .PIPE_LAT (PIPE_LAT)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .cfg_j       (cfg_j),
        .cfg_l       (cfg_l),
        .cfg_count   (cfg_count),
        .stall       (stall),
        .abort       (abort),
        .agu_clr     (agu_clr),
        .agu_step    (agu_step),
        .agu_j       (agu_j),
        .agu_l       (agu_l),
        .busy        (busy),
        .remaining   (remaining),
        .done        (done),
        .aborted     (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NJUMPS*BWADDR-1:0] j_of(input int id);
        j_of = {BWADDR'(id + 1), BWADDR'(21'h1F000 ^ id), BWADDR'(id * 7),
                BWADDR'(21'h0ABCD + id), BWADDR'(100 + id)};
    endfunction

    function automatic logic [(NJUMPS-1)*BWLENGTH-1:0] l_of(input int id);
        l_of = {BWLENGTH'(id), BWLENGTH'(8'h5A), BWLENGTH'(3 * id + 1), BWLENGTH'(8'hF0)};
    endfunction

    task automatic clear_rem_exp();
        for (int i = 0; i < 16; i++) rem_exp[i] = -1;
    endtask

    // Accept a job at the cycle-0 edge, then run cycles 1..ncyc checking the
    // expected timelines. cfg inputs are scrambled after acceptance so any
    // failure to latch shows up on agu_j/agu_l.
    task automatic run_job(input int id, input logic [BWCOUNT-1:0] cnt,
                           input logic [31:0] stall_m, input int abort_c,
                           input logic [31:0] exp_step, input int exp_done,
                           input int exp_abt, input int ncyc);
        int end_c;
        end_c       = (exp_done != 0) ? exp_done : exp_abt;
        cfg_j       = j_of(id);
        cfg_l       = l_of(id);
        cfg_count   = cnt;
        start_valid = 1'b1;
        stall       = 1'b0;
        abort       = 1'b0;
        #1;
        check_val($sformatf("j%0d c0 start_ready", id), 128'(start_ready), 128'(1));
        @(posedge clk); #1;
        start_valid = 1'b0;
        cfg_j       = ~j_of(id);
        cfg_l       = ~l_of(id);
        cfg_count   = '1;
        for (int c = 1; c <= ncyc; c++) begin
            stall = stall_m[c];
            abort = (c == abort_c);
            #1;
            check_val($sformatf("j%0d c%0d step", id, c),    128'(agu_step),    128'(exp_step[c]));
            check_val($sformatf("j%0d c%0d clr", id, c),     128'(agu_clr),     128'(c == 1));
            check_val($sformatf("j%0d c%0d done", id, c),    128'(done),        128'(c == exp_done));
            check_val($sformatf("j%0d c%0d aborted", id, c), 128'(aborted),     128'(c == exp_abt));
            check_val($sformatf("j%0d c%0d ready", id, c),   128'(start_ready), 128'(c >= end_c));
            check_val($sformatf("j%0d c%0d agu_j", id, c),   128'(agu_j),       128'(j_of(id)));
            check_val($sformatf("j%0d c%0d agu_l", id, c),   128'(agu_l),       128'(l_of(id)));
            if (c < 16 && rem_exp[c] >= 0)
                check_val($sformatf("j%0d c%0d remaining", id, c), 128'(remaining), 128'(rem_exp[c]));
            @(posedge clk); #1;
        end
        stall = 1'b0;
        abort = 1'b0;
        clear_rem_exp();
    endtask

    initial begin
        rst_n       = 1'b0;
        start_valid = 1'b0;
        cfg_j       = '0;
        cfg_l       = '0;
        cfg_count   = '0;
        stall       = 1'b0;
        abort       = 1'b0;
        clear_rem_exp();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst clr",       128'(agu_clr),   128'(1));
        check_val("rst busy",      128'(busy),      128'(0));
        check_val("rst remaining", 128'(remaining), 128'(0));
        check_val("rst agu_j",     128'(agu_j),     128'(0));
        rst_n = 1'b1;
        #1;
        check_val("post-rst clr",   128'(agu_clr),     128'(0));
        check_val("post-rst ready", 128'(start_ready), 128'(1));
        check_val("post-rst done",  128'(done),        128'(0));
        @(posedge clk); #1;

        // Job 1: count 5, no stall -> steps 2..6, done 9
        rem_exp[1] = 5; rem_exp[2] = 5; rem_exp[6] = 1; rem_exp[7] = 0; rem_exp[9] = 0;
        run_job(1, 24'd5, 32'h0, 0, 32'h0000_007C, 9, 0, 10);

        // Job 2: count 4, stall in 3-4 -> steps 2,5,6,7, done 10
        rem_exp[1] = 4; rem_exp[2] = 4; rem_exp[3] = 3; rem_exp[4] = 3;
        rem_exp[5] = 3; rem_exp[6] = 2; rem_exp[7] = 1; rem_exp[8] = 0;
        run_job(2, 24'd4, 32'h0000_0018, 0, 32'h0000_00E4, 10, 0, 11);

        // Job 3: count 0 -> clear only, done 2
        rem_exp[1] = 0; rem_exp[2] = 0;
        run_job(3, 24'd0, 32'h0, 0, 32'h0, 2, 0, 3);

        // Job 4: count 6, abort in cycle 4 -> steps 2,3, aborted 5, remaining 4
        rem_exp[4] = 4; rem_exp[5] = 4; rem_exp[6] = 4;
        run_job(4, 24'd6, 32'h0, 4, 32'h0000_000C, 0, 5, 7);

        // Job 5: reset for one cycle during RUN
        cfg_j = j_of(5); cfg_l = l_of(5); cfg_count = 24'd5; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check_val("j5 rst-cycle clr", 128'(agu_clr), 128'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check_val("j5 after-rst busy",      128'(busy),        128'(0));
        check_val("j5 after-rst ready",     128'(start_ready), 128'(1));
        check_val("j5 after-rst agu_j",     128'(agu_j),       128'(0));
        check_val("j5 after-rst agu_l",     128'(agu_l),       128'(0));
        check_val("j5 after-rst remaining", 128'(remaining),   128'(0));
        check_val("j5 after-rst done",      128'(done),        128'(0));
        check_val("j5 after-rst aborted",   128'(aborted),     128'(0));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check_val($sformatf("j5 idle%0d done", k), 128'(done),     128'(0));
            check_val($sformatf("j5 idle%0d step", k), 128'(agu_step), 128'(0));
        end

        // Job 6: start_valid held with a second job queued behind a count-2 job.
        // First job steps 2,3 and finishes in cycle 6; second is taken there.
        cfg_j = j_of(6); cfg_l = l_of(6); cfg_count = 24'd2; start_valid = 1'b1;
        @(posedge clk); #1;
        cfg_j = j_of(7); cfg_l = l_of(7); cfg_count = 24'd3;
        for (int c = 1; c <= 6; c++) begin
            #1;
            check_val($sformatf("j6 c%0d ready", c), 128'(start_ready), 128'(c == 6));
            check_val($sformatf("j6 c%0d done", c),  128'(done),        128'(c == 6));
            check_val($sformatf("j6 c%0d agu_j", c), 128'(agu_j),       128'(j_of(6)));
            @(posedge clk); #1;
        end
        start_valid = 1'b0;
        #1;
        check_val("j7 c7 clr",       128'(agu_clr),   128'(1));
        check_val("j7 c7 busy",      128'(busy),      128'(1));
        check_val("j7 c7 agu_j",     128'(agu_j),     128'(j_of(7)));
        check_val("j7 c7 agu_l",     128'(agu_l),     128'(l_of(7)));
        check_val("j7 c7 remaining", 128'(remaining), 128'(3));
        // Second job: steps 8,9,10, done 13
        for (int c = 8; c <= 13; c++) begin
            @(posedge clk); #1;
            check_val($sformatf("j7 c%0d step", c), 128'(agu_step), 128'(c >= 8 && c <= 10));
            check_val($sformatf("j7 c%0d done", c), 128'(done),     128'(c == 13));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
